// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: unit selects, function codes and FSM states.
package alu_pkg;

    // Unit select, carried in ALU_FUN[3:2]
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    // Full 4-bit ALU_FUN encodings: {unit, function within unit}
    typedef enum logic [3:0] {
        FUN_ADD     = 4'b0000,
        FUN_SUB     = 4'b0001,
        FUN_MUL     = 4'b0010,
        FUN_DIV     = 4'b0011,
        FUN_AND     = 4'b0100,
        FUN_OR      = 4'b0101,
        FUN_NAND    = 4'b0110,
        FUN_NOR     = 4'b0111,
        FUN_CMP_NOP = 4'b1000,
        FUN_CMP_EQ  = 4'b1001,
        FUN_CMP_GT  = 4'b1010,
        FUN_CMP_LT  = 4'b1011,
        FUN_SHR_A   = 4'b1100,
        FUN_SHL_A   = 4'b1101,
        FUN_SHR_B   = 4'b1110,
        FUN_SHL_B   = 4'b1111
    } alu_fun_e;

    // Issuer state machine: one operation in flight at a time
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

    // Unit addressed by a function code
    function automatic logic [1:0] fun_unit(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and response handshakes between a command source/sink and the ALU issuer.
interface alu_cmd_issuer_if #(
    parameter int IN_DATA_WIDTH = 16,
    parameter int ARITH_WIDTH   = 2 * IN_DATA_WIDTH,
    parameter int TAG_WIDTH     = 4
);
    // Command channel
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic        [3:0]               cmd_fun;
    logic signed [IN_DATA_WIDTH-1:0] cmd_a;
    logic signed [IN_DATA_WIDTH-1:0] cmd_b;
    logic        [TAG_WIDTH-1:0]     cmd_tag;

    // Response channel
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic        [ARITH_WIDTH-1:0]   rsp_data;
    logic                            rsp_carry;
    logic        [TAG_WIDTH-1:0]     rsp_tag;
    logic                            rsp_err;

    // Source/sink side: issues commands, accepts responses
    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err
    );

    // Issuer side: accepts commands, produces responses
    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err
    );

endinterface

// File: rtl/alu_rsp_mux.sv
// Selects result data, valid flag and carry of the ALU unit addressed by the function code.
module alu_rsp_mux
    import alu_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 16,
    parameter int ARITH_WIDTH   = 2 * IN_DATA_WIDTH
) (
    input  logic [1:0]               unit_i,
    input  logic [ARITH_WIDTH-1:0]   arith_out_i,
    input  logic                     carry_out_i,
    input  logic                     arith_flag_i,
    input  logic [IN_DATA_WIDTH-1:0] logic_out_i,
    input  logic                     logic_flag_i,
    input  logic [IN_DATA_WIDTH-1:0] cmp_out_i,
    input  logic                     cmp_flag_i,
    input  logic [IN_DATA_WIDTH-1:0] shift_out_i,
    input  logic                     shift_flag_i,
    output logic [ARITH_WIDTH-1:0]   data_o,
    output logic                     flag_o,
    output logic                     carry_o
);

    // Unit select; narrow results are unsigned bit patterns and are zero-extended
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        data_o  = '0;
        flag_o  = 1'b0;
        carry_o = 1'b0;
        case (unit_i)
            UNIT_ARITH: begin
                data_o  = arith_out_i;
                flag_o  = arith_flag_i;
                carry_o = carry_out_i;
            end
            UNIT_LOGIC: begin
                data_o = ARITH_WIDTH'(logic_out_i);
                flag_o = logic_flag_i;
            end
            UNIT_CMP: begin
                data_o = ARITH_WIDTH'(cmp_out_i);
                flag_o = cmp_flag_i;
            end
            default: begin
                data_o = ARITH_WIDTH'(shift_out_i);
                flag_o = shift_flag_i;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to the signed ALU, waits for the selected unit's flag
// (bounded by MAX_WAIT cycles) and returns a tagged response.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 16,
    parameter int ARITH_WIDTH   = 2 * IN_DATA_WIDTH,
    parameter int TAG_WIDTH     = 4,
    parameter int MAX_WAIT      = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    alu_cmd_issuer_if.slave                 bus,
    output logic signed [IN_DATA_WIDTH-1:0] A,
    output logic signed [IN_DATA_WIDTH-1:0] B,
    output logic        [3:0]               ALU_FUN,
    input  logic        [ARITH_WIDTH-1:0]   Arith_OUT,
    input  logic                            Carry_OUT,
    input  logic                            Arith_Flag,
    input  logic        [IN_DATA_WIDTH-1:0] Logic_OUT,
    input  logic                            Logic_Flag,
    input  logic        [IN_DATA_WIDTH-1:0] CMP_OUT,
    input  logic                            CMP_Flag,
    input  logic        [IN_DATA_WIDTH-1:0] Shift_OUT,
    input  logic                            Shift_Flag,
    output logic        [15:0]              op_count
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    issuer_state_e              state_q;
    logic [IN_DATA_WIDTH-1:0]   a_q;
    logic [IN_DATA_WIDTH-1:0]   b_q;
    logic [3:0]                 fun_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [ARITH_WIDTH-1:0]     data_q;
    logic                       carry_q;
    logic                       err_q;
    logic                       valid_q;
    logic [15:0]                count_q;
    logic [15:0]                count_d;
    logic [WAIT_W-1:0]          wait_q;
    logic [WAIT_W-1:0]          wait_d;

    logic [ARITH_WIDTH-1:0]     sel_data;
    logic                       sel_flag;
    logic                       sel_carry;
    logic                       cmd_accept;

    alu_rsp_mux #(
        .IN_DATA_WIDTH (IN_DATA_WIDTH),
        .ARITH_WIDTH   (ARITH_WIDTH)
    ) u_rsp_mux (
        .unit_i       (fun_unit(fun_q)),
        .arith_out_i  (Arith_OUT),
        .carry_out_i  (Carry_OUT),
        .arith_flag_i (Arith_Flag),
        .logic_out_i  (Logic_OUT),
        .logic_flag_i (Logic_Flag),
        .cmp_out_i    (CMP_OUT),
        .cmp_flag_i   (CMP_Flag),
        .shift_out_i  (Shift_OUT),
        .shift_flag_i (Shift_Flag),
        .data_o       (sel_data),
        .flag_o       (sel_flag),
        .carry_o      (sel_carry)
    );

    // Ready is a pure decode of IDLE, held low while reset is applied
    assign bus.cmd_ready = RST && (state_q == ST_IDLE);
    assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;
    assign wait_d        = wait_q + WAIT_W'(1);
    assign count_d       = count_q + 16'd1;

    // Control FSM with registered operand, response and counter outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        a_q     <= bus.cmd_a;
                        b_q     <= bus.cmd_b;
                        fun_q   <= bus.cmd_fun;
                        tag_q   <= bus.cmd_tag;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ALU samples the operands this cycle
                    wait_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sel_flag) begin
                        data_q  <= sel_data;
                        carry_q <= sel_carry;
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_RESP;
                    end else if (wait_q == WAIT_LAST) begin
                        data_q  <= '0;
                        carry_q <= 1'b0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign A             = a_q;
    assign B             = b_q;
    assign ALU_FUN       = fun_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_err   = err_q;
    assign op_count      = count_q;

endmodule
